// File: rtl/trace_chk_pkg.sv
// Shared types and helpers for the commit-trace self-check monitor.
package trace_chk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {F_PC, F_INST, F_RESULT, F_RDATA} field_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam int         NUM_FIELDS = 4;

  // Saturating increment; callers zero-extend narrower counters and pass their own ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction

  // Lowest-numbered failing field out of a per-field mismatch vector.
  function automatic field_e first_field(input logic [NUM_FIELDS-1:0] mis);
    if (mis[0])      return F_PC;
    else if (mis[1]) return F_INST;
    else if (mis[2]) return F_RESULT;
    else             return F_RDATA;
  endfunction

endpackage

// File: rtl/trace_table.sv
// Expected-trace storage: DEPTH entries of {PC, INST, RESULT, RDATA}.
// Single field write port, whole-entry asynchronous read. Not reset, so a
// loaded trace survives a reset of the checker.
module trace_table
  import trace_chk_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                                 clock,
  input  logic                                 wen,
  input  logic [IDX_W-1:0]                     wr_idx,
  input  logic [1:0]                           wr_field,
  input  logic [XLEN-1:0]                      wr_data,
  input  logic [IDX_W-1:0]                     rd_idx,
  output logic [NUM_FIELDS-1:0][XLEN-1:0]      rd_entry
);

  logic [NUM_FIELDS-1:0][XLEN-1:0] mem [DEPTH];

  // Field-granular write; the other three fields of the entry are untouched.
  always_ff @(posedge clock) begin
    if (wen) mem[wr_idx][wr_field] <= wr_data;
  end

  assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/commit_trace_checker.sv
// Commit-trace checker: compares each retired instruction of the CPU against
// a preloaded expected trace and reports pass/fail, error statistics, the
// first failing entry, the run length and a no-commit watchdog abort.
module commit_trace_checker
  import trace_chk_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 32,
  parameter int IDX_W       = $clog2(DEPTH),
  parameter int TIMEOUT     = 256,
  parameter int STOP_ON_ERR = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             io_cfgWen,
  input  logic [IDX_W-1:0] io_cfgIdx,
  input  logic [1:0]       io_cfgField,
  input  logic [XLEN-1:0]  io_cfgData,
  input  logic [IDX_W:0]   io_traceLen,
  input  logic             io_start,
  input  logic             io_commitValid,
  input  logic [XLEN-1:0]  io_currentPC,
  input  logic [31:0]      io_currentInst,
  input  logic [XLEN-1:0]  io_aluResult,
  input  logic             io_dmemWen,
  input  logic [XLEN-1:0]  io_dmemWData,
  input  logic [XLEN-1:0]  io_dmemRData,
  output logic             io_busy,
  output logic             io_done,
  output logic             io_pass,
  output logic             io_timeout,
  output logic [15:0]      io_errCount,
  output logic [IDX_W-1:0] io_firstErrIdx,
  output logic [1:0]       io_firstErrField,
  output logic [31:0]      io_cycleCount
);

  localparam int             WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0] LEN_ONE = 1;

  state_e                          state;
  logic [IDX_W-1:0]                idx;
  logic [IDX_W:0]                  trace_len;
  logic [WD_W-1:0]                 watchdog;
  logic [15:0]                     err_count;
  logic [IDX_W-1:0]                first_err_idx;
  logic [1:0]                      first_err_field;
  logic [31:0]                     cycle_count;
  logic                            timeout;

  logic [NUM_FIELDS-1:0][XLEN-1:0] entry;
  logic [NUM_FIELDS-1:0]           mis;
  logic [XLEN-1:0]                 result_obs;
  logic                            any_mis;
  logic                            last_entry;
  logic                            wd_hit;

  // Writes are only accepted while no run is in progress.
  trace_table #(.XLEN(XLEN), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_table (
    .clock    (clock),
    .wen      (io_cfgWen && (state != RUN)),
    .wr_idx   (io_cfgIdx),
    .wr_field (io_cfgField),
    .wr_data  (io_cfgData),
    .rd_idx   (idx),
    .rd_entry (entry)
  );

  // Stores report their data as the result; everything else reports the ALU output.
  assign result_obs = io_dmemWen ? io_dmemWData : io_aluResult;

  // Per-field compare of the current entry; RDATA only matters for loads.
  always_comb begin
    mis           = '0;
    mis[F_PC]     = entry[F_PC]     != io_currentPC;
    mis[F_INST]   = entry[F_INST]   != XLEN'(io_currentInst);
    mis[F_RESULT] = entry[F_RESULT] != result_obs;
    mis[F_RDATA]  = (io_currentInst[6:0] == OPC_LOAD) && (entry[F_RDATA] != io_dmemRData);
  end

  assign any_mis    = |mis;
  assign last_entry = {1'b0, idx} == (trace_len - LEN_ONE);
  assign wd_hit     = (32'(watchdog) + 32'd1) >= 32'(TIMEOUT);

  // Run-control FSM with its counters, first-error capture and watchdog.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      idx             <= '0;
      trace_len       <= '0;
      watchdog        <= '0;
      err_count       <= '0;
      first_err_idx   <= '0;
      first_err_field <= '0;
      cycle_count     <= '0;
      timeout         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (io_start) begin
            idx             <= '0;
            trace_len       <= io_traceLen;
            watchdog        <= '0;
            err_count       <= '0;
            first_err_idx   <= '0;
            first_err_field <= '0;
            cycle_count     <= '0;
            timeout         <= 1'b0;
            state           <= (io_traceLen == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          cycle_count <= sat_inc(cycle_count, 32'hFFFF_FFFF);
          if (io_commitValid) begin
            // A commit always clears the watchdog, even on the cycle it would expire.
            watchdog <= '0;
            idx      <= idx + 1'b1;
            if (any_mis) begin
              err_count <= 16'(sat_inc(32'(err_count), 32'h0000_FFFF));
              if (err_count == '0) begin
                first_err_idx   <= idx;
                first_err_field <= first_field(mis);
              end
            end
            if (last_entry || ((STOP_ON_ERR != 0) && any_mis)) state <= DONE;
          end else if (wd_hit) begin
            timeout <= 1'b1;
            state   <= DONE;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_busy          = state == RUN;
  assign io_done          = state == DONE;
  assign io_pass          = (state == DONE) && (err_count == '0) && !timeout;
  assign io_timeout       = timeout;
  assign io_errCount      = err_count;
  assign io_firstErrIdx   = first_err_idx;
  assign io_firstErrField = first_err_field;
  assign io_cycleCount    = cycle_count;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Bench for commit_trace_checker: an 11-entry lw/sw program trace replayed
// into two checkers (stop-on-error and run-to-end), with expected end-of-run
// results queued at launch and compared when the runs complete.
module tb_commit_trace_checker;

  localparam int XLEN = 32, DEPTH = 32, IDX_W = 5, NENT = 11;

  logic clock = 1'b0;
  logic reset_n;
  logic cfg_wen;
  logic [IDX_W-1:0] cfg_idx;
  logic [1:0] cfg_field;
  logic [XLEN-1:0] cfg_data;
  logic [IDX_W:0] trace_len;
  logic start, commit_valid, dmem_wen;
  logic [XLEN-1:0] cur_pc, alu, wdata, rdata;
  logic [31:0] cur_inst;

  logic a_busy, a_done, a_pass, a_to, b_busy, b_done, b_pass, b_to;
  logic [15:0] a_err, b_err;
  logic [IDX_W-1:0] a_fidx, b_fidx;
  logic [1:0] a_ff, b_ff;
  logic [31:0] a_cyc, b_cyc;

  always #5 clock = ~clock;

  commit_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(8), .STOP_ON_ERR(1)) u_a (
    .clock(clock), .reset_n(reset_n), .io_cfgWen(cfg_wen), .io_cfgIdx(cfg_idx),
    .io_cfgField(cfg_field), .io_cfgData(cfg_data), .io_traceLen(trace_len), .io_start(start),
    .io_commitValid(commit_valid), .io_currentPC(cur_pc), .io_currentInst(cur_inst),
    .io_aluResult(alu), .io_dmemWen(dmem_wen), .io_dmemWData(wdata), .io_dmemRData(rdata),
    .io_busy(a_busy), .io_done(a_done), .io_pass(a_pass), .io_timeout(a_to),
    .io_errCount(a_err), .io_firstErrIdx(a_fidx), .io_firstErrField(a_ff), .io_cycleCount(a_cyc));

  commit_trace_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(8), .STOP_ON_ERR(0)) u_b (
    .clock(clock), .reset_n(reset_n), .io_cfgWen(cfg_wen), .io_cfgIdx(cfg_idx),
    .io_cfgField(cfg_field), .io_cfgData(cfg_data), .io_traceLen(trace_len), .io_start(start),
    .io_commitValid(commit_valid), .io_currentPC(cur_pc), .io_currentInst(cur_inst),
    .io_aluResult(alu), .io_dmemWen(dmem_wen), .io_dmemWData(wdata), .io_dmemRData(rdata),
    .io_busy(b_busy), .io_done(b_done), .io_pass(b_pass), .io_timeout(b_to),
    .io_errCount(b_err), .io_firstErrIdx(b_fidx), .io_firstErrField(b_ff), .io_cycleCount(b_cyc));

  typedef struct {
    logic        pass;
    logic        timeout;
    logic [15:0] err;
    logic [4:0]  fidx;
    logic [1:0]  ffield;
    logic [31:0] cyc;
  } res_t;

  res_t qa[$];
  res_t qb[$];
  int vectors = 0;
  int miscompares = 0;

  // CPU-side view of the program: x1=-1 -> [128], x5=0x87654321 -> [256]
  logic [31:0] s_pc[NENT], s_inst[NENT], s_alu[NENT], s_wd[NENT], s_rd[NENT];
  logic        s_wen[NENT];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic res_t mk(input logic p, input logic t, input int e, input int fi,
                              input int ff, input int c);
    res_t r;
    r.pass = p; r.timeout = t; r.err = 16'(e); r.fidx = 5'(fi); r.ffield = 2'(ff); r.cyc = 32'(c);
    return r;
  endfunction

  task automatic wr(input int i, input int f, input logic [31:0] d);
    cfg_wen = 1'b1; cfg_idx = 5'(i); cfg_field = 2'(f); cfg_data = d;
    tick();
    cfg_wen = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < NENT; i++) begin
      wr(i, 0, s_pc[i]);
      wr(i, 1, s_inst[i]);
      wr(i, 2, s_wen[i] ? s_wd[i] : s_alu[i]);
      wr(i, 3, s_rd[i]);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Junk on wdata/rdata when unused so a wrong mux or ungated RDATA compare shows up.
  task automatic set_commit(input int i);
    commit_valid = 1'b1;
    cur_pc = s_pc[i]; cur_inst = s_inst[i]; alu = s_alu[i]; dmem_wen = s_wen[i];
    wdata = s_wen[i] ? s_wd[i] : 32'h5a5a5a5a;
    rdata = (s_inst[i][6:0] == 7'b0000011) ? s_rd[i] : 32'hdeadbeef;
  endtask

  task automatic commit(input int i);
    set_commit(i);
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic expect_run(input res_t ea, input res_t eb);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic cmp_res(input string tag, input res_t e, input logic done, input logic busy,
                         input logic pass, input logic to, input logic [15:0] err,
                         input logic [4:0] fidx, input logic [1:0] ff, input logic [31:0] cyc);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".pass"}, 32'(pass), 32'(e.pass));
    chk({tag, ".timeout"}, 32'(to), 32'(e.timeout));
    chk({tag, ".err"}, 32'(err), 32'(e.err));
    chk({tag, ".fidx"}, 32'(fidx), 32'(e.fidx));
    chk({tag, ".ffield"}, 32'(ff), 32'(e.ffield));
    chk({tag, ".cyc"}, cyc, e.cyc);
  endtask

  task automatic finish_run(input string tag);
    res_t ea, eb;
    int n = 0;
    while (!(a_done && b_done) && n < 500) begin
      tick();
      n++;
    end
    chk({tag, ".reached_done"}, 32'(a_done && b_done), 32'd1);
    if (qa.size() == 0 || qb.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      cmp_res({tag, "_a"}, ea, a_done, a_busy, a_pass, a_to, a_err, a_fidx, a_ff, a_cyc);
      cmp_res({tag, "_b"}, eb, b_done, b_busy, b_pass, b_to, b_err, b_fidx, b_ff, b_cyc);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".a_busy"}, 32'(a_busy), 0);
    chk({tag, ".a_done"}, 32'(a_done), 0);
    chk({tag, ".a_pass"}, 32'(a_pass), 0);
    chk({tag, ".a_timeout"}, 32'(a_to), 0);
    chk({tag, ".a_err"}, 32'(a_err), 0);
    chk({tag, ".a_fidx"}, 32'(a_fidx), 0);
    chk({tag, ".a_ffield"}, 32'(a_ff), 0);
    chk({tag, ".a_cyc"}, a_cyc, 0);
    chk({tag, ".b_busy"}, 32'(b_busy), 0);
    chk({tag, ".b_cyc"}, b_cyc, 0);
  endtask

  initial begin
    s_inst = '{32'hfff00093, 32'h08102023, 32'h08002183, 32'h876542b7, 32'h32128293, 32'h10000313,
               32'h00532023, 32'h00032383, 32'h00718433, 32'h00832223, 32'h0000006f};
    s_alu  = '{32'hffffffff, 32'h00000080, 32'h00000080, 32'h87654000, 32'h87654321, 32'h00000100,
               32'h00000100, 32'h00000100, 32'h87654320, 32'h00000104, 32'h0000002c};
    s_wen  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    s_wd   = '{32'h0, 32'hffffffff, 32'h0, 32'h0, 32'h0, 32'h0, 32'h87654321, 32'h0, 32'h0,
               32'h87654320, 32'h0};
    s_rd   = '{32'h0, 32'h0, 32'hffffffff, 32'h0, 32'h0, 32'h0, 32'h0, 32'h87654321, 32'h0,
               32'h0, 32'h0};
    for (int i = 0; i < NENT; i++) s_pc[i] = 32'(i * 4);

    reset_n = 1'b0; cfg_wen = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_data = '0;
    trace_len = 6'(NENT); start = 1'b0; commit_valid = 1'b0; cur_pc = '0; cur_inst = '0;
    alu = '0; dmem_wen = 1'b0; wdata = '0; rdata = '0;
    #3;
    chk_cleared("reset");
    tick();
    reset_n = 1'b1;
    tick();

    load_all();

    // 1: clean back-to-back run
    do_start();
    expect_run(mk(1, 0, 0, 0, 0, 11), mk(1, 0, 0, 0, 0, 11));
    for (int i = 0; i < NENT; i++) commit(i);
    finish_run("t1");

    // 1b: 7 idle cycles before each commit; the commit lands as the watchdog would expire
    do_start();
    expect_run(mk(1, 0, 0, 0, 0, 88), mk(1, 0, 0, 0, 0, 88));
    for (int i = 0; i < NENT; i++) begin
      repeat (7) tick();
      commit(i);
    end
    finish_run("t1b");

    // 2: entry 2 RDATA corrupted
    wr(2, 3, 32'h0);
    do_start();
    expect_run(mk(0, 0, 1, 2, 3, 3), mk(0, 0, 1, 2, 3, 11));
    for (int i = 0; i < NENT; i++) commit(i);
    finish_run("t2");
    wr(2, 3, 32'hffffffff);

    // 3: entry 3 RESULT and entry 7 PC corrupted
    wr(3, 2, 32'h12345678);
    wr(7, 0, 32'h00000bad);
    do_start();
    expect_run(mk(0, 0, 1, 3, 2, 4), mk(0, 0, 2, 3, 2, 11));
    for (int i = 0; i < NENT; i++) commit(i);
    finish_run("t3");
    wr(3, 2, 32'h87654000);
    wr(7, 0, 32'h0000001c);

    // 4: no commits -> watchdog abort after 8 cycles
    do_start();
    expect_run(mk(0, 1, 0, 0, 0, 8), mk(0, 1, 0, 0, 0, 8));
    finish_run("t4");

    // 5: reset pulse in the middle of a run, then a clean rerun
    do_start();
    for (int i = 0; i < 5; i++) commit(i);
    chk("t5.pre_busy", 32'(a_busy), 1);
    set_commit(5);
    reset_n = 1'b0;
    #1;
    chk_cleared("t5");
    commit_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    do_start();
    expect_run(mk(1, 0, 0, 0, 0, 11), mk(1, 0, 0, 0, 0, 11));
    for (int i = 0; i < NENT; i++) commit(i);
    finish_run("t5_rerun");

    // 6a: zero-length trace
    trace_len = '0;
    do_start();
    chk("t6a.done_next", 32'(a_done), 1);
    expect_run(mk(1, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0));
    finish_run("t6a");
    trace_len = 6'(NENT);

    // 6b: table write and start pulse during RUN are both ignored
    do_start();
    for (int i = 0; i < 3; i++) commit(i);
    cfg_wen = 1'b1; cfg_idx = 5'd9; cfg_field = 2'd0; cfg_data = 32'h00000bad;
    commit(3);
    cfg_wen = 1'b0;
    commit(4);
    start = 1'b1; trace_len = '0;
    commit(5);
    start = 1'b0; trace_len = 6'(NENT);
    for (int i = 6; i < NENT; i++) commit(i);
    expect_run(mk(1, 0, 0, 0, 0, 11), mk(1, 0, 0, 0, 0, 11));
    finish_run("t6b");

    // 6c: short trace ends on the commit of entry traceLen-1
    trace_len = 6'd4;
    do_start();
    expect_run(mk(1, 0, 0, 0, 0, 4), mk(1, 0, 0, 0, 0, 4));
    for (int i = 0; i < 4; i++) commit(i);
    finish_run("t6c");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
